target_io_arbiter: RTL and testbench

Parametrised, register-programmable driver arbiter for the target-facing I/O pins (IO1-IO4, nRST, PDID, PDIC, MOSI, SCK and similar). It replaces fixed per-pin ternary muxing in the top level. Each of pNUM_PINS pins selects one of pNUM_SRC internal sources, or high-Z. Source changes go through a break-before-make guard interval, so two drivers never fight on a pin. It sits on the shared register bus beside the other reg_* blocks, and its read data joins the OR-aggregated reg_datai.

---
 rtl/target_io_pkg.sv | 23 ++
 rtl/target_io_pinmux.sv | 59 +++++
 rtl/target_io_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_target_io_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/target_io_pkg.sv
// Shared definitions for the target I/O driver arbiter.
// Holds the changeover FSM encoding, the select-code width, the high-Z
// code and a helper that decides whether a select code names a real source.
package target_io_pkg;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned GUARD_W = 8;

    localparam logic [SEL_W-1:0] CODE_HIZ = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2
    } state_e;

    // Code k (1..num_src) selects source k-1; 0 and out-of-range codes mean high-Z.
    function automatic logic code_valid(input logic [SEL_W-1:0] code,
                                        input int unsigned      num_src);
        return (code != CODE_HIZ) && (32'(code) <= num_src);
    endfunction

endpackage

// File: rtl/target_io_pinmux.sv
// One target pin: decodes the select code into a source, applies the
// break-before-make force and the target-power override, and registers the pad.
// Ports:
//   clk_usb, reset_i   clock and synchronous active-high reset
//   code_i             select code in effect for this pin
//   forcez_i           hold the pin high-Z during a changeover
//   npower_i           target power off, forces high-Z
//   src_data_i/src_oe_i  candidate source values / enables for this pin
//   pin_o, pin_oe      registered pad output value / enable
module target_io_pinmux
    import target_io_pkg::*;
#(
    parameter int unsigned pNUM_SRC = 4
) (
    input  logic                clk_usb,
    input  logic                reset_i,
    input  logic [SEL_W-1:0]    code_i,
    input  logic                forcez_i,
    input  logic                npower_i,
    input  logic [pNUM_SRC-1:0] src_data_i,
    input  logic [pNUM_SRC-1:0] src_oe_i,
    output logic                pin_o,
    output logic                pin_oe
);

    logic pin_o_q, pin_o_d;
    logic pin_oe_q, pin_oe_d;
    logic src_data_c, src_oe_c;

    // Source select; an invalid code leaves both value and enable low.
    always_comb begin
        src_data_c = 1'b0;
        src_oe_c   = 1'b0;
        if (code_valid(code_i, pNUM_SRC)) begin
            for (int unsigned s = 0; s < pNUM_SRC; s++) begin
                if (code_i == SEL_W'(s + 1)) begin
                    src_data_c = src_data_i[s];
                    src_oe_c   = src_oe_i[s];
                end
            end
        end
        pin_o_d  = src_data_c;
        pin_oe_d = !npower_i && !forcez_i && src_oe_c;
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            pin_o_q  <= 1'b0;
            pin_oe_q <= 1'b0;
        end else begin
            pin_o_q  <= pin_o_d;
            pin_oe_q <= pin_oe_d;
        end
    end

    assign pin_o  = pin_o_q;
    assign pin_oe = pin_oe_q;

endmodule

// File: rtl/target_io_arbiter.sv
// Register-programmable driver arbiter for the target-facing pins.
// Each pin picks one of pNUM_SRC sources or high-Z; any change of source
// passes through a high-Z guard interval so two drivers never overlap.
// Optional build macro: TARGET_IO_READBACK_EN adds a 2-flop synchroniser on
// pin_i and returns it through status bytes 1+ (otherwise those read 0).
// Ports:
//   clk_usb, reset_i          bus clock, synchronous active-high reset
//   reg_address/bytecnt/datai register bus address, byte index, write data
//   reg_read/reg_write        bus strobes
//   reg_datao                 registered read data, 0 when not addressed
//   target_npower             target power off, forces every pin high-Z
//   src_data/src_oe           per-pin source values/enables, pin p source s at p*pNUM_SRC+s
//   pin_i                     asynchronous pad inputs (readback only)
//   pin_o/pin_oe              registered pad value/enable
//   busy                      changeover in progress
module target_io_arbiter
    import target_io_pkg::*;
#(
    parameter int unsigned                   pNUM_PINS     = 8,
    parameter int unsigned                   pNUM_SRC      = 4,
    parameter int unsigned                   pGUARD_CYCLES = 4,
    parameter int unsigned                   pADDR_WIDTH   = 8,
    parameter logic [pADDR_WIDTH-1:0]        pSEL_ADDR     = 8'd70,
    parameter logic [pADDR_WIDTH-1:0]        pSTAT_ADDR    = 8'd71
) (
    input  logic                          clk_usb,
    input  logic                          reset_i,
    input  logic [pADDR_WIDTH-1:0]        reg_address,
    input  logic [7:0]                    reg_bytecnt,
    input  logic [7:0]                    reg_datai,
    output logic [7:0]                    reg_datao,
    input  logic                          reg_read,
    input  logic                          reg_write,
    input  logic                          target_npower,
    input  logic [pNUM_PINS*pNUM_SRC-1:0] src_data,
    input  logic [pNUM_PINS*pNUM_SRC-1:0] src_oe,
    input  logic [pNUM_PINS-1:0]          pin_i,
    output logic [pNUM_PINS-1:0]          pin_o,
    output logic [pNUM_PINS-1:0]          pin_oe,
    output logic                          busy
);

    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(pGUARD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [GUARD_W-1:0]   guard_q, guard_d;
    logic [SEL_W-1:0]     pending_q   [pNUM_PINS];
    logic [SEL_W-1:0]     pending_d   [pNUM_PINS];
    logic [SEL_W-1:0]     committed_q [pNUM_PINS];
    logic [SEL_W-1:0]     committed_d [pNUM_PINS];
    logic [pNUM_PINS-1:0] forcez_q, forcez_d;
    logic [pNUM_PINS-1:0] diff_c, mask_c;
    logic                 busy_q, busy_d;
    logic [7:0]           datao_q, datao_d;
    logic [15:0]          sync_pad_c;
    logic                 sel_wr_c;

    assign sel_wr_c = reg_write && (reg_address == pSEL_ADDR) &&
                      (reg_bytecnt < 8'(pNUM_PINS));

    // Pending select update and per-pin pending/committed mismatch.
    always_comb begin
        for (int unsigned p = 0; p < pNUM_PINS; p++) begin
            pending_d[p] = pending_q[p];
            if (sel_wr_c && (reg_bytecnt == 8'(p))) begin
                pending_d[p] = reg_datai[SEL_W-1:0];
            end
            diff_c[p] = (pending_q[p] != committed_q[p]);
        end
    end

    // Changeover FSM. mask_c is the forced-Z set seen by the pins this cycle;
    // in MAKE the pins already see the value being committed so the new
    // source drives on the edge that returns to IDLE.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        forcez_d  = forcez_q;
        mask_c    = '0;
        for (int unsigned p = 0; p < pNUM_PINS; p++) begin
            committed_d[p] = committed_q[p];
        end

        case (state_q)
            ST_IDLE: begin
                mask_c   = diff_c;
                forcez_d = diff_c;
                if (|diff_c) begin
                    state_d = ST_BREAK;
                    guard_d = GUARD_LOAD;
                end
            end
            ST_BREAK: begin
                // Forced set is sticky: a pin written back to its old code still waits out the guard.
                mask_c   = forcez_q | diff_c;
                forcez_d = mask_c;
                if (sel_wr_c) begin
                    guard_d = GUARD_LOAD;
                end else if (guard_q == '0) begin
                    state_d = ST_MAKE;
                end else begin
                    guard_d = guard_q - GUARD_W'(1);
                end
            end
            ST_MAKE: begin
                mask_c   = '0;
                forcez_d = '0;
                state_d  = ST_IDLE;
                for (int unsigned p = 0; p < pNUM_PINS; p++) begin
                    committed_d[p] = pending_q[p];
                end
            end
            default: begin
                state_d  = ST_IDLE;
                forcez_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Read mux; zero unless a matching address is being read so the bus can be OR-ed.
    always_comb begin
        datao_d = '0;
        if (reg_read) begin
            if (reg_address == pSEL_ADDR) begin
                for (int unsigned p = 0; p < pNUM_PINS; p++) begin
                    if (reg_bytecnt == 8'(p)) begin
                        datao_d = 8'(pending_q[p]);
                    end
                end
            end else if (reg_address == pSTAT_ADDR) begin
                if (reg_bytecnt == 8'd0) begin
                    datao_d = {busy_q, state_q, 5'b0};
                end else if (reg_bytecnt == 8'd1) begin
                    datao_d = sync_pad_c[7:0];
                end else if (reg_bytecnt == 8'd2) begin
                    datao_d = sync_pad_c[15:8];
                end
            end
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            guard_q  <= '0;
            forcez_q <= '0;
            busy_q   <= 1'b0;
            datao_q  <= '0;
            for (int unsigned p = 0; p < pNUM_PINS; p++) begin
                pending_q[p]   <= CODE_HIZ;
                committed_q[p] <= CODE_HIZ;
            end
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            forcez_q <= forcez_d;
            busy_q   <= busy_d;
            datao_q  <= datao_d;
            for (int unsigned p = 0; p < pNUM_PINS; p++) begin
                pending_q[p]   <= pending_d[p];
                committed_q[p] <= committed_d[p];
            end
        end
    end

`ifdef TARGET_IO_READBACK_EN
    logic [pNUM_PINS-1:0] sync1_q, sync1_d;
    logic [pNUM_PINS-1:0] sync2_q, sync2_d;
    logic                 unused_bits;

    assign sync1_d = pin_i;
    assign sync2_d = sync1_q;

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync_pad_c  = 16'(sync2_q);
    assign unused_bits = ^reg_datai[7:SEL_W];
`else
    logic unused_bits;

    assign sync_pad_c  = '0;
    assign unused_bits = ^{reg_datai[7:SEL_W], pin_i};
`endif

    for (genvar p = 0; p < pNUM_PINS; p++) begin : g_pin
        target_io_pinmux #(
            .pNUM_SRC (pNUM_SRC)
        ) u_pinmux (
            .clk_usb    (clk_usb),
            .reset_i    (reset_i),
            .code_i     (committed_d[p]),
            .forcez_i   (mask_c[p]),
            .npower_i   (target_npower),
            .src_data_i (src_data[p*pNUM_SRC +: pNUM_SRC]),
            .src_oe_i   (src_oe[p*pNUM_SRC +: pNUM_SRC]),
            .pin_o      (pin_o[p]),
            .pin_oe     (pin_oe[p])
        );
    end

    assign busy      = busy_q;
    assign reg_datao = datao_q;

endmodule

// File: tb/tb_target_io_arbiter.sv
// Directed bench for target_io_arbiter with default parameters
// (8 pins, 4 sources, 4 guard cycles, select at 70, status at 71).
module tb_target_io_arbiter;

    localparam logic [7:0] SEL_A  = 8'd70;
    localparam logic [7:0] STAT_A = 8'd71;

    logic        clk_usb = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  reg_address = '0;
    logic [7:0]  reg_bytecnt = '0;
    logic [7:0]  reg_datai = '0;
    logic [7:0]  reg_datao;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        target_npower = 1'b0;
    logic [31:0] src_data = '0;
    logic [31:0] src_oe = '0;
    logic [7:0]  pin_i = '0;
    logic [7:0]  pin_o;
    logic [7:0]  pin_oe;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] rv;
    logic [7:0] exp_rb;

    target_io_arbiter dut (
        .clk_usb       (clk_usb),
        .reset_i       (reset_i),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_datai     (reg_datai),
        .reg_datao     (reg_datao),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .target_npower (target_npower),
        .src_data      (src_data),
        .src_oe        (src_oe),
        .pin_i         (pin_i),
        .pin_o         (pin_o),
        .pin_oe        (pin_oe),
        .busy          (busy)
    );

    always #5 clk_usb = ~clk_usb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic [7:0] d);
        reg_address = SEL_A;
        reg_bytecnt = b;
        reg_datai   = d;
        reg_write   = 1'b1;
        tick();
        reg_write   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] b, output logic [7:0] v);
        reg_address = a;
        reg_bytecnt = b;
        reg_read    = 1'b1;
        tick();
        v = reg_datao;
        reg_read    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef TARGET_IO_READBACK_EN
        exp_rb = 8'hA5;
`else
        exp_rb = 8'h00;
`endif
        // Reset state
        repeat (3) tick();
        reset_i = 1'b0;
        check("rst_oe", 32'(pin_oe), 32'h00);
        check("rst_o", 32'(pin_o), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        rd(SEL_A, 8'd3, rv);
        check("rst_sel3", 32'(rv), 32'h00);

        // Pin 2 -> source 2 (bit 10), source toggling through the changeover
        src_oe[10]   = 1'b1;
        src_data[10] = 1'b0;
        wr(8'd2, 8'd3);
        check("t2_busy_t1", 32'(busy), 32'h0);
        reg_read    = 1'b1;
        reg_address = STAT_A;
        reg_bytecnt = 8'd0;
        for (int k = 2; k <= 7; k++) begin
            src_data[10] = k[0];
            tick();
            if (k < 7) begin
                check($sformatf("t2_busy_%0d", k), 32'(busy), 32'h1);
                check($sformatf("t2_oe_%0d", k), 32'(pin_oe), 32'h00);
                check($sformatf("t2_o_%0d", k), 32'(pin_o), 32'h00);
                check($sformatf("t2_stat_%0d", k), 32'(reg_datao), (k == 2) ? 32'h00 : 32'hA0);
            end else begin
                check("t2_busy_7", 32'(busy), 32'h0);
                check("t2_oe_7", 32'(pin_oe), 32'h04);
                check("t2_o_7", 32'(pin_o), 32'h04);
                check("t2_stat_7", 32'(reg_datao), 32'hC0);
            end
        end
        reg_read = 1'b0;
        src_data[10] = 1'b0;
        tick();
        check("t2_follow0", 32'(pin_o), 32'h00);
        src_data[10] = 1'b1;
        tick();
        check("t2_follow1", 32'(pin_o), 32'h04);

        // Pin 1 on source 0, then code 2 and back to code 1 mid-guard
        src_oe[4] = 1'b1; src_data[4] = 1'b1;
        src_oe[5] = 1'b1; src_data[5] = 1'b0;
        wr(8'd1, 8'd1);
        repeat (6) tick();
        check("t3_oe_init", 32'(pin_oe), 32'h06);
        check("t3_o_init", 32'(pin_o), 32'h06);
        wr(8'd1, 8'd2);
        check("t3_oe_t1", 32'(pin_oe), 32'h06);
        tick();
        check("t3_oe_t2", 32'(pin_oe), 32'h04);
        check("t3_busy_t2", 32'(busy), 32'h1);
        tick();
        check("t3_oe_t3", 32'(pin_oe), 32'h04);
        wr(8'd1, 8'd1);
        check("t3_oe_t4", 32'(pin_oe), 32'h04);
        for (int k = 5; k <= 8; k++) begin
            tick();
            check($sformatf("t3_oe_t%0d", k), 32'(pin_oe), 32'h04);
            check($sformatf("t3_busy_t%0d", k), 32'(busy), 32'h1);
        end
        tick();
        check("t3_oe_t9", 32'(pin_oe), 32'h06);
        check("t3_o_t9", 32'(pin_o), 32'h06);
        check("t3_busy_t9", 32'(busy), 32'h0);

        // Target power off: all high-Z, commits continue
        src_oe[12] = 1'b1; src_data[12] = 1'b1;
        target_npower = 1'b1;
        tick();
        check("t4_oe_off", 32'(pin_oe), 32'h00);
        wr(8'd3, 8'd1);
        repeat (5) tick();
        check("t4_busy", 32'(busy), 32'h1);
        tick();
        check("t4_busy_done", 32'(busy), 32'h0);
        check("t4_oe_still", 32'(pin_oe), 32'h00);
        check("t4_o", 32'(pin_o), 32'h0E);
        rd(SEL_A, 8'd3, rv);
        check("t4_sel3", 32'(rv), 32'h01);
        target_npower = 1'b0;
        tick();
        check("t4_oe_on", 32'(pin_oe), 32'h0E);

        // Out-of-range code and out-of-range byte index
        src_oe[19:16]   = 4'hF;
        src_data[19:16] = 4'hF;
        wr(8'd4, 8'd6);
        repeat (6) tick();
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_oe", 32'(pin_oe), 32'h0E);
        check("t5_o", 32'(pin_o), 32'h0E);
        rd(SEL_A, 8'd4, rv);
        check("t5_sel4", 32'(rv), 32'h06);
        wr(8'd9, 8'd1);
        tick();
        check("t5_busy_b9", 32'(busy), 32'h0);
        rd(SEL_A, 8'd9, rv);
        check("t5_sel9", 32'(rv), 32'h00);
        check("t5_oe_b9", 32'(pin_oe), 32'h0E);

        // Rewriting the committed value does nothing
        wr(8'd3, 8'd1);
        tick();
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_oe", 32'(pin_oe), 32'h0E);

        // Pad readback through the synchroniser
        pin_i       = 8'hA5;
        reg_read    = 1'b1;
        reg_address = STAT_A;
        reg_bytecnt = 8'd1;
        tick();
        tick();
        check("t7_rb_c2", 32'(reg_datao), 32'h00);
        tick();
        check("t7_rb_c3", 32'(reg_datao), 32'(exp_rb));
        reg_read = 1'b0;
        rd(STAT_A, 8'd2, rv);
        check("t7_stat2", 32'(rv), 32'h00);
        rd(8'd10, 8'd0, rv);
        check("t7_noaddr", 32'(rv), 32'h00);
        reg_address = SEL_A;
        reg_bytecnt = 8'd1;
        tick();
        check("t7_noread", 32'(reg_datao), 32'h00);

        // Reset in the middle of a guard interval
        wr(8'd1, 8'd2);
        tick();
        tick();
        check("t8_busy_pre", 32'(busy), 32'h1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t8_busy", 32'(busy), 32'h0);
        check("t8_oe", 32'(pin_oe), 32'h00);
        check("t8_o", 32'(pin_o), 32'h00);
        rd(SEL_A, 8'd1, rv);
        check("t8_sel1", 32'(rv), 32'h00);
        repeat (6) tick();
        check("t8_oe_late", 32'(pin_oe), 32'h00);
        check("t8_busy_late", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
